// File: rtl/sha256_arb_pkg.sv
// Shared types for the sha256 core arbiter: FSM encoding and digest width.
package sha256_arb_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        RESP       = 3'd4
    } arb_state_t;

    localparam int DIGEST_W = 256;

    typedef logic [DIGEST_W-1:0] digest_t;

endpackage

// File: rtl/sha256_arbiter_rr.sv
// Round-robin priority rotation: the first asserted request searching from
// ptr+1 (modulo N_REQ) wins. Purely combinational; grant is zero unless en.
module rr_arbiter
    import sha256_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx
);

    // Candidate index for each search offset: w_cand[k] = (ptr + 1 + k) mod N_REQ.
    // ptr never exceeds N_REQ-1, so one conditional subtract is enough.
    logic [ID_W-1:0] w_cand [N_REQ];
    logic [ID_W-1:0] w_pick;
    logic            w_any;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [ID_W:0] w_sum;
            assign w_sum       = {1'b0, ptr} + (ID_W+1)'(gi + 1);
            assign w_cand[gi]  = (w_sum >= (ID_W+1)'(N_REQ))
                               ? ID_W'(w_sum - (ID_W+1)'(N_REQ))
                               : w_sum[ID_W-1:0];
        end
    endgenerate

    // Scan offsets from last to first so the lowest offset with a request wins.
    always_comb begin
        w_pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                w_pick = w_cand[k];
            end
        end
    end

    assign w_any = en && (|req);
    assign idx   = w_any ? w_pick : '0;
    assign grant = w_any ? (N_REQ'(1) << w_pick) : '0;

endmodule

// File: rtl/sha256_arbiter.sv
// Shares one sha256_top core between N_REQ requesters. A round-robin winner's
// num is latched, the core is started with a single en pulse, its rdy
// handshake is followed to completion and the digest is returned with the
// winner's ID through a one-entry response buffer. A watchdog converts a hung
// core into an error response. TIMEOUT must be at least 2.
module sha256_arbiter
    import sha256_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int NUM_W   = 32,
    parameter int TIMEOUT = 4096,
    parameter int ID_W    = $clog2(N_REQ)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*NUM_W-1:0]   req_num,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_err,
    output logic [DIGEST_W-1:0]      rsp_digest,
    output logic                     core_en,
    output logic [NUM_W-1:0]         core_num,
    input  logic                     core_rdy,
    input  logic [DIGEST_W-1:0]      core_digest,
    output logic                     busy
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [NUM_W-1:0]  r_num;
    logic [WD_W-1:0]   r_wdog;
    logic [WD_W-1:0]   w_wdog_next;
    logic              r_rsp_err;
    digest_t           r_rsp_digest;

    logic [NUM_W-1:0]  w_slice [N_REQ];
    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_grant_idx;
    logic              w_arb_en;
    logic              w_granted;
    logic              w_waiting;
    logic              w_done;
    logic              w_timeout;

    // Split the flat num bus into one word per requester.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_slice[gi] = req_num[gi*NUM_W +: NUM_W];
        end
    endgenerate

    // Grants only happen from IDLE with an idle core; gating with rst_n keeps
    // req_ready at 0 while reset is held.
    assign w_arb_en = (r_state == IDLE) && core_rdy && rst_n;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (r_ptr),
        .en    (w_arb_en),
        .grant (w_grant),
        .idx   (w_grant_idx)
    );

    assign w_granted   = |w_grant;
    assign w_waiting   = (r_state == WAIT_START) || (r_state == WAIT_DONE);
    assign w_wdog_next = r_wdog + WD_W'(1);
    assign w_done      = (r_state == WAIT_DONE) && core_rdy;
    // The watchdog fires in the cycle its count would reach TIMEOUT-1, which
    // puts the error response exactly TIMEOUT cycles after the en pulse.
    // A coinciding done takes precedence.
    assign w_timeout   = w_waiting && (w_wdog_next == WD_LAST) && !w_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a timeout while still waiting for the start
    // acknowledge also ends the job.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_granted) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_state_next = WAIT_START;
            end
            WAIT_START: begin
                if (w_timeout) begin
                    w_state_next = RESP;
                end else if (!core_rdy) begin
                    w_state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (w_done || w_timeout) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Grant capture: the winner becomes the rotation pointer and the response
    // ID, and its num is frozen for the whole job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= ID_W'(N_REQ - 1);
            r_id  <= '0;
            r_num <= '0;
        end else if (w_granted) begin
            r_ptr <= w_grant_idx;
            r_id  <= w_grant_idx;
            r_num <= w_slice[w_grant_idx];
        end
    end

    // Watchdog: cleared on the en pulse, counts while waiting on the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state == ISSUE) begin
            r_wdog <= '0;
        end else if (w_waiting) begin
            r_wdog <= w_wdog_next;
        end
    end

    // Response buffer: digest on done, zero digest with err on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_err    <= 1'b0;
            r_rsp_digest <= '0;
        end else if (w_done) begin
            r_rsp_err    <= 1'b0;
            r_rsp_digest <= core_digest;
        end else if (w_timeout) begin
            r_rsp_err    <= 1'b1;
            r_rsp_digest <= '0;
        end
    end

    assign req_ready  = w_grant;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_err    = r_rsp_err;
    assign rsp_digest = r_rsp_digest;
    assign core_en    = (r_state == ISSUE);
    assign core_num   = r_num;
    assign busy       = (r_state != IDLE);

endmodule

// File: doc/sha256_arbiter.md
Name: sha256_arbiter

Overview:
Shares one sha256_top hashing core between N_REQ requesters, such as CFU ops from several harts or a DMA. Round-robin arbitration selects a requester. The block then pulses the core enable once, tracks the core's rdy handshake through busy and done, and captures the 256-bit digest A..H. The digest is returned with the winner's ID through a single-entry response buffer. A watchdog turns a hung core into an error response instead of a deadlock.

Parameters:
N_REQ, 4, number of requesters (2..16)
NUM_W, 32, width of the core's num (block-count) input
TIMEOUT, 4096, max cycles from enable pulse to done before error
ID_W, $clog2(N_REQ), requester index width

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
req_valid  in  N_REQ  per-requester request
req_num  in  N_REQ*NUM_W  per-requester num; slice i belongs to requester i
req_ready  out  N_REQ  one-hot accept; request i consumed when req_valid[i]&req_ready[i]
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  requester index of response
rsp_err  out  1  1 = watchdog timeout, digest invalid
rsp_digest  out  256  {A,B,C,D,E,F,G,H}, A in [255:224]
core_en  out  1  single-cycle start pulse to sha256_top.en
core_num  out  NUM_W  to sha256_top.num, stable from ISSUE through done
core_rdy  in  1  sha256_top.rdy (1 = idle/done)
core_digest  in  256  {A_final..H_final} from core
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer = N_REQ-1 so requester 0 has first priority, watchdog counter 0, latched num/id/digest 0.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- IDLE:
  - Grant only if core_rdy=1 and |req_valid.
  - Winner is the first valid index searching from ptr+1, wrapping modulo N_REQ.
  - req_ready[winner]=1 combinationally in that cycle.
  - Latch req_num slice and id; ptr <= winner; next state ISSUE.
  - req_ready is 0 in every other state and when core_rdy=0.
- ISSUE: core_en=1 for exactly this one cycle; watchdog cleared to 0; next state WAIT_START.
- WAIT_START:
  - core_rdy=0 -> WAIT_DONE. This is the core acknowledging the start.
  - core_rdy still 1 -> remain; the core may take more than one cycle to drop rdy.
- WAIT_DONE: core_rdy=1 -> capture core_digest into rsp_digest, rsp_err=0, next state RESP.
- Watchdog:
  - Increments every cycle in WAIT_START and WAIT_DONE.
  - On reaching TIMEOUT-1 without done: rsp_err=1, rsp_digest=0, next state RESP.
  - If timeout and done coincide in the same cycle, done wins (rsp_err=0).
- RESP:
  - rsp_valid=1; rsp_id/rsp_err/rsp_digest held stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid&rsp_ready -> next state IDLE, rsp_valid=0 the next cycle.
  - No new grant occurs in the handshake cycle.
- After an error, IDLE re-grants only once core_rdy=1, so a stuck core starves no one silently: busy=0 and req_ready stays 0.
- Latency, no backpressure, core done D cycles after its start:
  - grant at T, core_en at T+1.
  - core_rdy falls at T+2 at the earliest.
  - rsp_valid the cycle after core_rdy rises.
- Fairness: a continuously requesting index waits at most N_REQ-1 grants.
- req_num is sampled only at grant; later changes are ignored.
- rst_n assertion mid-operation immediately returns to reset values, dropping any in-flight response. The core shares rst_n, so both restart together.
- Requester protocol: req_valid must not drop before req_ready; violation is undefined (assertion in bench).

Decomposition:
- Package sha256_arb_pkg:
  - typedef enum logic [2:0] arb_state_t {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP}
  - localparam DIGEST_W=256
  - typedef logic [DIGEST_W-1:0] digest_t
- Sub-module rr_arbiter (params N_REQ): inputs req, ptr, en; outputs one-hot grant and encoded index; purely combinational priority rotation.
- The FSM, watchdog and response buffer stay in sha256_arbiter.

Test Plan:
- Single requester 0, req_num=32, core model done 80 cycles after en -> one core_en pulse at T+1; rsp_id=0, rsp_err=0, rsp_digest equals model digest; busy low after handshake.
- req_valid=4'b1111 held, 4 jobs -> grant order 0,1,2,3, then 0 again; core_num equals each slice value (e.g. 10,20,30,40).
- Hold rsp_ready=0 for 50 cycles after completion -> rsp_valid/rsp_digest stable, req_ready all 0, no core_en; release -> next grant the cycle after the handshake.
- Core model never raises rdy, TIMEOUT=16 -> rsp_err=1 and digest 0 exactly 16 cycles after core_en; no regrant until core_rdy=1.
- Core holds rdy=0 at idle -> req_valid asserted gives no req_ready and no core_en; rdy=1 -> grant the same cycle.
- Assert rst_n low during WAIT_DONE -> all outputs 0 asynchronously; after release, requester 0 has priority again and a fresh job completes correctly.
